// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and frame layout.
// Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

   localparam int FRAME_BITS = 10;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_REL
   } ps2_tx_state_t;

   // Bit 0 goes out first; bit 9 is the stop bit.
   function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
      return {1'b1, ~^data, data};
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and open-drain line bundle for the PS/2 host transmitter.
// The slave modport is the transmitter; master is the controller plus the line model.
interface ps2_host_tx_if;
   logic       start;
   logic [7:0] tx_data;
   logic       busy;
   logic       done;
   logic       err;
   logic       rx_en;
   logic       ps2c_in;
   logic       ps2d_in;
   logic       ps2c_oe;
   logic       ps2d_oe;

   modport master (
      output start, tx_data, ps2c_in, ps2d_in,
      input  busy, done, err, rx_en, ps2c_oe, ps2d_oe
   );

   modport slave (
      input  start, tx_data, ps2c_in, ps2d_in,
      output busy, done, err, rx_en, ps2c_oe, ps2d_oe
   );
endinterface

// File: rtl/ps2_edge_filter.sv
// Two-flop synchroniser, glitch filter and falling-edge strobe for a PS/2 clock line.
// A new level is accepted only after FILTER_LEN consecutive samples agree.
module ps2_edge_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic line_in,
   output logic level,
   output logic fall
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sync  <= 2'b11;
         cnt   <= '0;
         level <= 1'b1;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[0], line_in};
         fall <= 1'b0;
         // Any sample matching the current level restarts the run of disagreeing samples.
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync[1];
            fall  <= ~sync[1];
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10-bit frame, device ack.
// Define PS2_TX_ACK_CHECK_EN to turn a missing device ack into an err pulse.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic          clk,
   input  logic          reset,
   ps2_host_tx_if.slave  bus
);

   // state     | meaning
   // ST_IDLE   | lines released, receiver enabled, waiting for start
   // ST_INHIBIT| ps2c held low; start bit asserted in the last cycle
   // ST_REQ    | ps2c released, ps2d low, waiting for the device's first edge
   // ST_SHIFT  | one frame bit per device falling edge
   // ST_ACK    | stop bit out, sampling the device ack on the next edge
   // ST_WAIT_REL| waiting for the device to release both lines

   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int BIT_W = $clog2(FRAME_BITS);

   localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

   ps2_tx_state_t         state, state_d;
   logic [FRAME_BITS-1:0] frame, frame_d;
   logic [BIT_W-1:0]      bit_cnt, bit_cnt_d;
   logic [INH_W-1:0]      inh_cnt, inh_cnt_d;
   logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_d;
   logic                  d_drive, d_drive_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  tmo_active;
`ifdef PS2_TX_ACK_CHECK_EN
   logic                  ack_bad, ack_bad_d;
`endif

   logic       c_level;
   logic       c_fall;
   logic [1:0] d_meta;
   logic       d_sync;

   ps2_edge_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .clk_sys (clk),
      .rst_b   (reset),
      .line_in (bus.ps2c_in),
      .level   (c_level),
      .fall    (c_fall)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) d_meta <= 2'b11;
      else        d_meta <= {d_meta[0], bus.ps2d_in};
   end
   assign d_sync = d_meta[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         frame   <= '0;
         bit_cnt <= '0;
         inh_cnt <= '0;
         tmo_cnt <= TMO_LOAD;
         d_drive <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
         ack_bad <= 1'b0;
`endif
      end else begin
         state   <= state_d;
         frame   <= frame_d;
         bit_cnt <= bit_cnt_d;
         inh_cnt <= inh_cnt_d;
         tmo_cnt <= tmo_cnt_d;
         d_drive <= d_drive_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef PS2_TX_ACK_CHECK_EN
         ack_bad <= ack_bad_d;
`endif
      end
   end

   assign tmo_active = (state == ST_REQ) || (state == ST_SHIFT) ||
                       (state == ST_ACK) || (state == ST_WAIT_REL);

   always_comb begin
      state_d   = state;
      frame_d   = frame;
      bit_cnt_d = bit_cnt;
      inh_cnt_d = inh_cnt;
      d_drive_d = d_drive;
      done_d    = 1'b0;
      err_d     = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_bad_d = ack_bad;
`endif

      // Watchdog reloads on every device edge and idles outside the device-paced states.
      if (!tmo_active || c_fall)  tmo_cnt_d = TMO_LOAD;
      else if (tmo_cnt != '0)     tmo_cnt_d = tmo_cnt - TMO_W'(1);
      else                        tmo_cnt_d = tmo_cnt;

      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               frame_d   = ps2_frame(bus.tx_data);
               bit_cnt_d = '0;
               inh_cnt_d = INH_LOAD;
               d_drive_d = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
               ack_bad_d = 1'b0;
`endif
               state_d   = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (inh_cnt == '0) state_d = ST_REQ;
            else               inh_cnt_d = inh_cnt - INH_W'(1);
         end
         ST_REQ: begin
            if (c_fall) begin
               d_drive_d = ~frame[0];
               bit_cnt_d = BIT_W'(1);
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (c_fall) begin
               d_drive_d = ~frame[bit_cnt];
               bit_cnt_d = bit_cnt + BIT_W'(1);
               if (bit_cnt == BIT_LAST) state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (c_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
               ack_bad_d = d_sync;
`endif
               state_d = ST_WAIT_REL;
            end
         end
         ST_WAIT_REL: begin
            if (c_level && d_sync) begin
               state_d = ST_IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
               err_d   = ack_bad;
               done_d  = ~ack_bad;
`else
               done_d  = 1'b1;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (tmo_active && !c_fall && tmo_cnt == '0) begin
         state_d   = ST_IDLE;
         d_drive_d = 1'b0;
         done_d    = 1'b0;
         err_d     = 1'b1;
      end
   end

   assign bus.busy    = (state != ST_IDLE);
   assign bus.rx_en   = (state == ST_IDLE);
   assign bus.ps2c_oe = (state == ST_INHIBIT);
   assign bus.ps2d_oe = ((state == ST_INHIBIT) && (inh_cnt == '0)) ||
                        (state == ST_REQ) ||
                        ((state == ST_SHIFT) && d_drive);
   assign bus.done    = done_q;
   assign bus.err     = err_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the send direction of the keyboard link whose receive side feeds the image-control keys. It takes a command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) and runs the full PS/2 host-request sequence on the shared open-drain ps2c/ps2d lines:

- clock inhibit
- start bit
- 8 data bits, LSB first
- odd parity
- stop bit
- device acknowledge

It drives the receiver's rx_en so the receiver ignores the link while a transmission is in progress.

## Interface
Parameters:
- INHIBIT_CYCLES, 10000: clk cycles ps2c is held low before the start bit (100 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum clk cycles between device falling edges, or waiting for line release, before the transfer is aborted (20 ms).
- FILTER_LEN, 8: consecutive equal samples needed to accept a new ps2c level.

Ports:
- clk, input, 1: system clock, single domain.
- reset, input, 1: asynchronous, active-low.
- start, input, 1: one-cycle request; accepted only when busy=0.
- tx_data, input, 8: command byte, latched when start is accepted.
- ps2c_in, input, 1: raw PS/2 clock line, asynchronous.
- ps2d_in, input, 1: raw PS/2 data line, asynchronous.
- ps2c_oe, output, 1: 1 pulls ps2c low; 0 releases it.
- ps2d_oe, output, 1: 1 pulls ps2d low; 0 releases it.
- busy, output, 1: high from the cycle after start is accepted until return to IDLE.
- done, output, 1: one-cycle pulse on successful completion.
- err, output, 1: one-cycle pulse on timeout, or on missing ack when the ack check is compiled in.
- rx_en, output, 1: high only in IDLE; connects to the keyboard receiver's rx_en.

## Operation
- States: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL.
- IDLE:
  - ps2c_oe=0, ps2d_oe=0, rx_en=1.
  - On start: latch tx_data and form the frame {stop=1, parity=~^tx_data, tx_data}, 10 bits.
  - Clear the bit counter and go to INHIBIT.
- INHIBIT:
  - ps2c_oe=1. Count INHIBIT_CYCLES.
  - ps2d_oe=1 (start bit) is asserted in the last inhibit cycle.
  - Then go to REQ.
- REQ:
  - ps2c_oe=0, ps2d_oe=1.
  - Wait for the first filtered ps2c falling edge, then go to SHIFT.
- SHIFT, one filtered falling edge per step:
  - Edge k drives frame bit k-1 for k=1..10: ps2d_oe = ~bit.
  - The 10th bit is the stop bit, so ps2d_oe=0.
  - After the 10th edge go to ACK.
- ACK:
  - On the next falling edge, sample ps2d_in; 0 means acknowledged.
  - Then go to WAIT_REL.
- WAIT_REL:
  - Wait until filtered ps2c=1 and ps2d_in=1.
  - Then pulse done (or err, see Configuration) and go to IDLE.
- Timeout:
  - Active in REQ, SHIFT, ACK and WAIT_REL.
  - The counter restarts on every filtered falling edge.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse err, go to IDLE.
- start while busy is ignored; no queueing.
- Input filtering:
  - ps2c_in and ps2d_in pass through 2-flop synchronisers.
  - ps2c is filtered by FILTER_LEN.
  - A falling edge is a filtered 1→0 transition.
- Reset at any point:
  - Immediately: ps2c_oe=0, ps2d_oe=0, busy=0, done=0, err=0, rx_en=1.
  - State returns to IDLE and all counters clear.

## Timing
- busy rises 1 cycle after the start cycle.
- ps2c_oe rises in the same cycle busy rises.
- ps2d_oe updates 1 cycle after a falling edge is detected.
- Edge detection lags the pin by 2 (sync) + FILTER_LEN cycles.
- done and err are mutually exclusive, last one cycle, and coincide with busy falling.
- A new start is accepted in the cycle after done or err.
- Counter widths are derived with $clog2 of their respective parameters.

## Configuration
- PS2_TX_ACK_CHECK_EN defined:
  - ps2d_in=1 at the ACK edge produces err instead of done. The line sequence is unchanged.
- PS2_TX_ACK_CHECK_EN undefined:
  - The ACK sample is ignored; completion always produces done unless a timeout occurs.

## Structure
- Shared package ps2_pkg, holding:
  - state enum (ps2_tx_state_t)
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4
  - FRAME_BITS=10
- One sub-module, ps2_edge_filter:
  - synchroniser, glitch filter and falling-edge strobe
  - reusable by the receiver.

## Test plan
- Send 0xED with a device model that clocks at 12.5 kHz and acks:
  - ps2c held low ≥ INHIBIT_CYCLES.
  - Data bits 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - done=1, err=0; rx_en low throughout and back to 1 after.
- Send 0x01:
  - Parity bit 0 on edge 9.
  - Stop on edge 10 releases ps2d (ps2d_oe=0).
- Device model stops clocking after edge 4:
  - After TIMEOUT_CYCLES, err pulses and both oe are 0.
  - busy=0 and the state is IDLE.
- Device withholds ack (ps2d_in=1) with PS2_TX_ACK_CHECK_EN defined:
  - err pulses.
- Same stimulus with the macro undefined:
  - done pulses.
- start pulsed again mid-transfer, and reset asserted during SHIFT:
  - The second start is ignored.
  - On reset, both lines are released asynchronously and busy=0.
  - A subsequent 0xF4 transfer completes with done.
- 1-cycle glitches on ps2c (shorter than FILTER_LEN):
  - No extra bit shift.
  - The frame still completes with done.
